// File: rtl/shape_processor_bridge_pkg.sv
// Shared types for the shape_processor command bridge: queued command
// record, bridge FSM states and the FIFO pointer-width helper.
package shape_processor_bridge_pkg;

    // One queued CTRL-SFR access; data is only meaningful for writes.
    typedef struct packed {
        logic        is_write;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } bridge_state_e;

    // Pointer width for a DEPTH-entry FIFO: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shape_cmd_fifo.sv
// Generic synchronous FIFO of cmd_t. Pointers carry an extra wrap bit so
// full and empty fall straight out of a pointer compare. The head entry is
// visible combinationally; the consumer registers it when it pops.
module shape_cmd_fifo
    import shape_processor_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_cmd,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    cmd_t             mem [DEPTH];

    logic do_push;
    logic do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer advance; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate access.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= push_cmd;
        end
    end

    assign head  = mem[rd_ptr_reg[IDX_W-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                   (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);

endmodule

// File: rtl/shape_processor_cmd_bridge.sv
// Upstream command bridge for shape_processor. Queues CTRL-SFR read/write
// requests, issues each as a one-cycle strobe, and hands the read data or
// write error back on a valid/ready response channel. Also keeps a
// saturating count of rejected writes.
module shape_processor_cmd_bridge
    import shape_processor_bridge_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               resp_error,
    output logic               write,
    output logic [31:0]        write_data,
    output logic               read,
    input  logic [31:0]        read_data,
    input  logic               error,
    output logic [COUNT_W-1:0] error_count,
    output logic               busy
);

    bridge_state_e      state_reg;
    bridge_state_e      state_next;
    logic               pop;
    logic               push;
    logic               full;
    logic               empty;
    cmd_t               req_cmd;
    cmd_t               head;

    logic               write_reg;
    logic               read_reg;
    logic [31:0]        write_data_reg;
    logic               resp_valid_reg;
    logic [31:0]        resp_rdata_reg;
    logic               resp_error_reg;
    logic [COUNT_W-1:0] error_count_reg;

    assign req_ready        = !full;
    assign push             = req_valid && req_ready;
    assign req_cmd.is_write = req_write;
    assign req_cmd.data     = req_wdata;

    shape_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_cmd (req_cmd),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a response handshake with work queued goes straight back
    // to ISSUE so back-to-back commands cost two cycles each.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!empty) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (resp_ready) state_next = empty ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: the head is popped whenever the FSM is about to enter ISSUE.
    always_comb begin
        pop = 1'b0;
        case (state_reg)
            IDLE:    pop = !empty;
            RESP:    pop = resp_ready && !empty;
            default: pop = 1'b0;
        endcase
    end

    // Strobe registers: loaded on pop so exactly one strobe is high during
    // ISSUE, cleared on every other edge. write_data only updates on writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg      <= 1'b0;
            read_reg       <= 1'b0;
            write_data_reg <= '0;
        end else begin
            write_reg <= 1'b0;
            read_reg  <= 1'b0;
            if (pop) begin
                write_reg <= head.is_write;
                read_reg  <= !head.is_write;
                if (head.is_write) begin
                    write_data_reg <= head.data;
                end
            end
        end
    end

    // Response capture at the end of ISSUE; held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_error_reg <= 1'b0;
        end else if (state_reg == ISSUE) begin
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= read_reg ? read_data : '0;
            resp_error_reg <= write_reg && error;
        end else if ((state_reg == RESP) && resp_ready) begin
            resp_valid_reg <= 1'b0;
        end
    end

    // Saturating count of writes that shape_processor rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count_reg <= '0;
        end else if ((state_reg == ISSUE) && write_reg && error &&
                     (error_count_reg != {COUNT_W{1'b1}})) begin
            error_count_reg <= error_count_reg + COUNT_W'(1);
        end
    end

    assign write       = write_reg;
    assign read        = read_reg;
    assign write_data  = write_data_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_rdata  = resp_rdata_reg;
    assign resp_error  = resp_error_reg;
    assign error_count = error_count_reg;
    assign busy        = (state_reg != IDLE) || !empty;

endmodule

// File: tb/tb_shape_processor_cmd_bridge.sv
// Self-checking bench for shape_processor_cmd_bridge. Expected responses are
// queued when a command is accepted and compared in order when the bridge
// hands them back. The downstream model returns read data 0xDEADBEEF XOR the
// number of reads already strobed, and flags a write error when write_data
// bit 31 is set or when err_force is raised.
module tb_shape_processor_cmd_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        error;
    logic [7:0]  error_count;
    logic        busy;

    logic        err_force;
    logic [31:0] rd_seen = '0;
    logic [31:0] rd_pushed;

    int          n_compared;
    int          n_mismatched;
    int          cyc;
    int          n_wr_strobes;
    int          n_rd_strobes;
    int          n_resp;
    int          exp_cnt;
    int          strobe_cyc[$];
    exp_t        sb[$];
    logic        hold_pending;
    logic [31:0] hold_rdata;
    logic        hold_err;

    always #5 clk = ~clk;

    shape_processor_cmd_bridge #(
        .DEPTH   (4),
        .COUNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .write       (write),
        .write_data  (write_data),
        .read        (read),
        .read_data   (read_data),
        .error       (error),
        .error_count (error_count),
        .busy        (busy)
    );

    // Downstream shape_processor model.
    assign read_data = 32'hDEAD_BEEF ^ rd_seen;
    assign error     = err_force | write_data[31];

    always @(posedge clk) begin
        if (read) rd_seen <= rd_seen + 32'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation, run once inputs for the cycle are final.
    task automatic monitor();
        exp_t e;
        if (rst_n) begin
            check_eq("strobe_excl", 32'(write && read), 32'd0);
            if (write || read) strobe_cyc.push_back(cyc);
            if (write) n_wr_strobes++;
            if (read) n_rd_strobes++;
            if (hold_pending) begin
                check_eq("hold_valid", 32'(resp_valid), 32'd1);
                check_eq("hold_rdata", resp_rdata, hold_rdata);
                check_eq("hold_error", 32'(resp_error), 32'(hold_err));
            end
            hold_pending = resp_valid && !resp_ready;
            hold_rdata   = resp_rdata;
            hold_err     = resp_error;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_resp++;
                    $display("resp %0d @cyc %0d: rdata=0x%08h error=%0b", n_resp, cyc, resp_rdata, resp_error);
                    check_eq("resp_rdata", resp_rdata, e.rdata);
                    check_eq("resp_error", 32'(resp_error), 32'(e.err));
                end
            end
        end
    endtask

    task automatic tick();
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_push(input logic w, input logic [31:0] d);
        exp_t e;
        if (w) begin
            e.rdata = 32'd0;
            e.err   = err_force | d[31];
            if (e.err && exp_cnt < 255) exp_cnt++;
        end else begin
            e.rdata   = 32'hDEAD_BEEF ^ rd_pushed;
            e.err     = 1'b0;
            rd_pushed = rd_pushed + 32'd1;
        end
        sb.push_back(e);
    endtask

    // Offer one command for up to max_wait cycles; returns with req_valid low.
    task automatic push_cmd(input logic w, input logic [31:0] d, input int max_wait, output bit ok);
        req_valid = 1'b1;
        req_write = w;
        req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                model_push(w, d);
                tick();
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic push(input logic w, input logic [31:0] d);
        bit ok;
        push_cmd(w, d, 50, ok);
        check_eq("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int max_wait);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (!busy && !resp_valid && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_eq("drain", 32'(done), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_ready"},  32'(req_ready),  32'd1);
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_resp_rdata"}, resp_rdata,      32'd0);
        check_eq({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        check_eq({tag, "_write"},      32'(write),      32'd0);
        check_eq({tag, "_read"},       32'(read),       32'd0);
        check_eq({tag, "_write_data"}, write_data,      32'd0);
        check_eq({tag, "_err_cnt"},    32'(error_count), 32'd0);
        check_eq({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        bit          ok;
        int          accepted;
        int          w0;
        int          r0;
        logic        st_w[6];
        logic [31:0] st_d[6];

        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        n_wr_strobes = 0;
        n_rd_strobes = 0;
        n_resp       = 0;
        exp_cnt      = 0;
        rd_pushed    = '0;
        hold_pending = 1'b0;
        hold_rdata   = '0;
        hold_err     = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        err_force    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        tick();
        tick();

        // Single clean write: strobe at push+2, response at push+3
        push_cmd(1'b1, 32'h0000_0011, 1, ok);
        check_eq("lat_accept", 32'(ok), 32'd1);
        check_eq("lat_n1_write", 32'(write), 32'd0);
        check_eq("lat_n1_busy", 32'(busy), 32'd1);
        tick();
        check_eq("lat_n2_write", 32'(write), 32'd1);
        check_eq("lat_n2_read", 32'(read), 32'd0);
        check_eq("lat_n2_wdata", write_data, 32'h0000_0011);
        tick();
        check_eq("lat_n3_valid", 32'(resp_valid), 32'd1);
        check_eq("lat_n3_write", 32'(write), 32'd0);
        check_eq("lat_n3_rdata", resp_rdata, 32'd0);
        check_eq("lat_n3_error", 32'(resp_error), 32'd0);
        wait_idle(20);
        check_eq("err_cnt_zero", 32'(error_count), 32'd0);

        // Rejected write, then saturate the counter
        push(1'b1, 32'h8000_0001);
        wait_idle(20);
        check_eq("err_cnt_one", 32'(error_count), 32'd1);
        for (int i = 2; i <= 300; i++) begin
            push(1'b1, 32'h8000_0000 | 32'(i));
        end
        wait_idle(50);
        check_eq("err_cnt_sat", 32'(error_count), 32'(exp_cnt));
        check_eq("err_cnt_model", 32'(exp_cnt), 32'd255);

        // Read ignores a simultaneous error and leaves the counter alone
        err_force = 1'b1;
        w0 = n_wr_strobes;
        r0 = n_rd_strobes;
        push(1'b0, 32'h0000_1234);
        wait_idle(20);
        err_force = 1'b0;
        check_eq("rd_strobes", 32'(n_rd_strobes - r0), 32'd1);
        check_eq("rd_no_write", 32'(n_wr_strobes - w0), 32'd0);
        check_eq("rd_err_cnt", 32'(error_count), 32'd255);

        // Back-to-back reads: strobes exactly two cycles apart
        strobe_cyc.delete();
        push(1'b0, 32'h0);
        push(1'b0, 32'h0);
        push(1'b0, 32'h0);
        wait_idle(30);
        check_eq("b2b_count", 32'(strobe_cyc.size()), 32'd3);
        if (strobe_cyc.size() == 3) begin
            check_eq("b2b_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd2);
            check_eq("b2b_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd2);
        end

        // Stalled response: one in flight plus four queued, then back-pressure
        st_w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        st_d = '{32'h0000_0005, 32'h0, 32'h8000_0007, 32'h0, 32'h0000_0009, 32'h0};
        resp_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            push_cmd(st_w[k], st_d[k], 4, ok);
            if (ok) accepted++;
        end
        check_eq("stall_accepted", 32'(accepted), 32'd5);
        check_eq("stall_req_ready", 32'(req_ready), 32'd0);
        check_eq("stall_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("stall_busy", 32'(busy), 32'd1);
        resp_ready = 1'b1;
        push(st_w[5], st_d[5]);
        wait_idle(60);

        // Reset asserted during ISSUE with two entries still queued
        resp_ready = 1'b0;
        push(1'b1, 32'h0000_0100);
        push(1'b1, 32'h0000_0101);
        push(1'b1, 32'h0000_0102);
        push(1'b1, 32'h0000_0103);
        check_eq("rst_pre_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        tick();
        check_eq("rst_pre_issue", 32'(write), 32'd1);
        check_eq("rst_pre_wdata", write_data, 32'h0000_0101);
        check_eq("rst_pre_cnt", 32'(error_count), 32'd255);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        sb.delete();
        exp_cnt = 0;
        hold_pending = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = n_wr_strobes;
        r0 = n_rd_strobes;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("post_rst_busy", 32'(busy), 32'd0);
        end
        check_eq("post_rst_wstrobe", 32'(n_wr_strobes - w0), 32'd0);
        check_eq("post_rst_rstrobe", 32'(n_rd_strobes - r0), 32'd0);
        push(1'b0, 32'h0);
        wait_idle(20);
        check_eq("post_rst_cnt", 32'(error_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
